// File: rtl/sd_decimator.sv
// Sinc^2 (2nd-order CIC) decimator: 1-bit delta-sigma stream in, saturated BW-bit samples out at 1/2**R_LOG2.
// Sample is registered 1 clock after the decimating bit; an unconsumed sample is overwritten and flagged by overrun_o.
module sd_decimator #(
    parameter int BW     = 16,
    parameter int R_LOG2 = 4,
    parameter bit POL    = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          bit_i,
    input  logic          bit_valid_i,
    output logic [BW-1:0] dout_o,
    output logic          dout_valid_o,
    input  logic          dout_ready_i,
    output logic          overrun_o
);

    localparam int W  = 2*R_LOG2 + 2;
    localparam int SH = BW - 1 - 2*R_LOG2;

    logic [W-1:0]      i1_q, i2_q, i2d_q, c1d_q;
    logic [W-1:0]      x, i1_n, i2_n, c1, c2;
    logic [BW:0]       y_wide;
    logic [BW-1:0]     y;
    logic [R_LOG2-1:0] phase_q;
    logic [1:0]        settle_q;
    logic              dec, load;

    always_comb begin
        x    = (bit_i ^ POL) ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
        i1_n = i1_q + x;
        i2_n = i2_q + i1_n;
        c1   = i2_n - i2d_q;
        c2   = c1 - c1d_q;
        // c2 shifted by SH fills exactly BW+1 bits; only +R^2 overflows the BW-bit range
        y_wide = {c2, {SH{1'b0}}};
        if (y_wide[BW] != y_wide[BW-1]) begin
            y = y_wide[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
        end else begin
            y = y_wide[BW-1:0];
        end
        dec  = bit_valid_i & (&phase_q);
        load = dec & (settle_q == 2'd2);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i1_q         <= '0;
            i2_q         <= '0;
            i2d_q        <= '0;
            c1d_q        <= '0;
            phase_q      <= '0;
            settle_q     <= 2'd0;
            dout_o       <= '0;
            dout_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (bit_valid_i) begin
                i1_q    <= i1_n;
                i2_q    <= i2_n;
                phase_q <= phase_q + R_LOG2'(1);
            end
            if (dec) begin
                i2d_q <= i2_n;
                c1d_q <= c1;
                if (settle_q != 2'd2) begin
                    settle_q <= settle_q + 2'd1;
                end
            end
            // A coincident transfer frees the register, so only a stalled consumer counts as overrun
            if (load) begin
                dout_o       <= y;
                dout_valid_o <= 1'b1;
                overrun_o    <= dout_valid_o & ~dout_ready_i;
            end else if (dout_valid_o && dout_ready_i) begin
                dout_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_decimator.sv
// Bench for sd_decimator: table-driven streams for POL=0/1 instances plus overrun and mid-frame reset sequences.
module tb_sd_decimator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_vld = 1'b0;
    logic        dout_rdy = 1'b0;
    logic [15:0] dout, dout_p;
    logic        dout_vld, dout_vld_p, ovr, ovr_p;

    always #5 clk = ~clk;

    sd_decimator #(.BW(16), .R_LOG2(4), .POL(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bit_i(bit_in), .bit_valid_i(bit_vld),
        .dout_o(dout), .dout_valid_o(dout_vld), .dout_ready_i(dout_rdy), .overrun_o(ovr)
    );

    sd_decimator #(.BW(16), .R_LOG2(4), .POL(1'b1)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .bit_i(bit_in), .bit_valid_i(bit_vld),
        .dout_o(dout_p), .dout_valid_o(dout_vld_p), .dout_ready_i(dout_rdy), .overrun_o(ovr_p)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: exact-integer integrators, second difference of I2 at decimation
    int mi1, mi2, md1, md2, ph, ndec;
    bit m_vld, m_ovr;
    int q0[$];
    int q1[$];
    int cyc, first_cyc, last0, last1, ovr_seen;

    typedef struct {
        bit [3:0] pat;
        int       plen;
        bit       vtog;
        int       ncyc;
        int       exp0;
        int       exp1;
        int       efirst;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_edge(input logic b, input logic v, input logic r);
        int  c2;
        bit  loaded;
        loaded = 1'b0;
        m_ovr  = 1'b0;
        if (v) begin
            mi1 += b ? 1 : -1;
            mi2 += mi1;
            ph++;
            if (ph == 16) begin
                ph = 0;
                c2 = mi2 - 2*md1 + md2;
                md2 = md1;
                md1 = mi2;
                ndec++;
                if (ndec > 2) begin
                    if (m_vld && !r) begin
                        m_ovr = 1'b1;
                        q0.delete(0);
                        q1.delete(0);
                    end
                    q0.push_back(sat(c2 * 128));
                    q1.push_back(sat(-c2 * 128));
                    m_vld  = 1'b1;
                    loaded = 1'b1;
                end
            end
        end
        if (!loaded && m_vld && r) m_vld = 1'b0;
    endtask

    // Drive one cycle's inputs, check the pre-edge outputs, advance the model, then wait for the edge
    task automatic step(input logic b, input logic v, input logic r);
        bit_in   = b;
        bit_vld  = v;
        dout_rdy = r;
        chk("valid", int'(dout_vld), int'(m_vld));
        chk("valid_p", int'(dout_vld_p), int'(m_vld));
        chk("overrun", int'(ovr), int'(m_ovr));
        chk("overrun_p", int'(ovr_p), int'(m_ovr));
        if (dout_vld && r) begin
            if (q0.size() == 0 || q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got a sample, expected none (t=%0t)", $time);
            end else begin
                last0 = int'($signed(dout));
                last1 = int'($signed(dout_p));
                chk("dout", last0, q0.pop_front());
                chk("dout_p", last1, q1.pop_front());
            end
        end
        model_edge(b, v, r);
        @(negedge clk);
        cyc++;
        if (ovr) ovr_seen++;
        if (dout_vld && first_cyc == 0) first_cyc = cyc;
    endtask

    // Called at a negedge; the reset lands between edges so the clear must be asynchronous
    task automatic do_reset();
        #2;
        rst_n    = 1'b0;
        bit_in   = 1'b0;
        bit_vld  = 1'b0;
        dout_rdy = 1'b0;
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_vld), 0);
        chk("rst_overrun", int'(ovr), 0);
        chk("rst_dout_p", int'(dout_p), 0);
        mi1 = 0; mi2 = 0; md1 = 0; md2 = 0; ph = 0; ndec = 0;
        m_vld = 1'b0; m_ovr = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        cyc       = 1;
        first_cyc = 0;
        ovr_seen  = 0;
    endtask

    initial begin
        // pat is indexed by accepted-bit count modulo plen; expected values are steady outputs for POL=0/1
        tbl[0] = '{pat: 4'b0001, plen: 1, vtog: 1'b0, ncyc: 100, exp0: 32767,  exp1: -32768, efirst: 49};
        tbl[1] = '{pat: 4'b0000, plen: 1, vtog: 1'b0, ncyc: 100, exp0: -32768, exp1: 32767,  efirst: 49};
        tbl[2] = '{pat: 4'b0101, plen: 2, vtog: 1'b0, ncyc: 100, exp0: 0,      exp1: 0,      efirst: 49};
        tbl[3] = '{pat: 4'b0111, plen: 4, vtog: 1'b0, ncyc: 100, exp0: 16384,  exp1: -16384, efirst: 49};
        tbl[4] = '{pat: 4'b0001, plen: 1, vtog: 1'b1, ncyc: 200, exp0: 32767,  exp1: -32768, efirst: 96};

        @(negedge clk);
        for (int t = 0; t < 5; t++) begin
            int  k;
            logic v, b;
            do_reset();
            k = 0;
            last0 = 12345;
            last1 = 12345;
            for (int c = 0; c < tbl[t].ncyc; c++) begin
                v = tbl[t].vtog ? (c % 2 == 0) : 1'b1;
                b = v ? tbl[t].pat[k % tbl[t].plen] : 1'($urandom_range(0, 1));
                if (v) k++;
                step(b, v, 1'b1);
            end
            chk($sformatf("row%0d_first", t), first_cyc, tbl[t].efirst);
            chk($sformatf("row%0d_last", t), last0, tbl[t].exp0);
            chk($sformatf("row%0d_last_p", t), last1, tbl[t].exp1);
        end

        // Stalled consumer across two decimations, then ready raised exactly on a decimation edge
        do_reset();
        for (int c = 0; c < 48; c++) step(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 31; c++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("newer_sample", last0, -2048);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b1);
        chk("overrun_pulses", ovr_seen, 1);

        // Reset mid-frame with a sample pending; settling restarts
        do_reset();
        for (int c = 0; c < 52; c++) step(1'b1, 1'b1, 1'b0);
        chk("pending_before_rst", int'(dout_vld), 1);
        do_reset();
        for (int c = 0; c < 60; c++) step(1'b1, 1'b1, 1'b1);
        chk("rst_first", first_cyc, 49);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_decimator.md
SD_DECIMATOR -- requirements
Module: sd_decimator

Interface
REQ-001 Parameter BW, default 16, is the width of the signed output sample; it SHALL be at least 2*R_LOG2+2.
REQ-002 Parameter R_LOG2, default 4, sets the decimation ratio R = 2**R_LOG2; it SHALL be in the range 1..6.
REQ-003 Parameter POL, default 0: with POL=0 bit 1 maps to +1 and bit 0 maps to -1; with POL=1 the mapping is inverted.
REQ-004 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset; assertion takes effect immediately, and deassertion is sampled on clk_i.
REQ-006 bit_i  in  1  delta-sigma bitstream input.
REQ-007 bit_valid_i  in  1  qualifies bit_i; a bit is accepted on a rising edge where bit_valid_i=1.
REQ-008 dout_o  out  BW  signed decimated sample.
REQ-009 dout_valid_o  out  1  dout_o holds an unconsumed sample.
REQ-010 dout_ready_i  in  1  consumer accepts the sample; a transfer occurs on an edge where dout_valid_o=1 and dout_ready_i=1.
REQ-011 overrun_o  out  1  one-cycle pulse marking that an unconsumed sample was overwritten.

Function
REQ-012 The block SHALL implement a 2nd-order CIC (sinc^2) decimator with ratio R and internal width W = 2*R_LOG2+2, using two's-complement wrap-around arithmetic throughout.
REQ-013 On each accepted bit, integrator 1 SHALL add the mapped value x (+1 or -1), and integrator 2 SHALL add the new value of integrator 1.
REQ-014 With bit_valid_i=0, the integrators, the phase counter and the comb state SHALL hold their values.
REQ-015 The phase counter SHALL count accepted bits from 0 to R-1 and wrap to 0; the edge that accepts a bit while the counter equals R-1 is the decimation edge.
REQ-016 On a decimation edge, the comb SHALL compute c1 = I2n - I2d and c2 = c1 - c1d, where I2n is the updated integrator 2 value; it SHALL then store I2d <= I2n and c1d <= c1.
REQ-017 c2 lies in [-R^2, +R^2]; the block SHALL form y = c2 * 2**(BW-1-2*R_LOG2) and saturate y to [-2**(BW-1), 2**(BW-1)-1], so +R^2 maps to the positive maximum.
REQ-018 A settle counter SHALL discard the first 2 decimated samples after reset; they SHALL update comb state but SHALL NOT load dout_o.
REQ-019 From the 3rd decimation onward, the decimation edge SHALL load dout_o with y and set dout_valid_o=1, visible in the cycle after the R-th accepted bit (latency 1 clock).
REQ-020 dout_o and dout_valid_o SHALL stay stable while dout_valid_o=1 and dout_ready_i=0, unless REQ-022 applies.
REQ-021 On a transfer with no simultaneous decimation, dout_valid_o SHALL clear on that edge; dout_o keeps its value.
REQ-022 If a decimation edge coincides with dout_valid_o=1 and dout_ready_i=0, the block SHALL overwrite dout_o, keep dout_valid_o=1, and pulse overrun_o=1 for one cycle.
REQ-023 If a decimation edge coincides with a transfer, the block SHALL load the new sample, keep dout_valid_o=1, and SHALL NOT assert overrun_o.
REQ-024 dout_ready_i SHALL have no effect while dout_valid_o=0.

Reset
REQ-025 While rst_ni=0, the block SHALL clear the integrators, I2d, c1d, the phase counter and the settle counter to 0, and SHALL drive dout_o=0, dout_valid_o=0 and overrun_o=0.
REQ-026 Reset asserted mid-frame or mid-handshake SHALL discard any pending sample; after release, the block SHALL again discard 2 decimated samples.

Verification
REQ-027 Defaults, bit_valid_i=1, all-ones stream, dout_ready_i=1 -> first dout_valid_o pulse 49 cycles after reset release (3rd decimation); from the 3rd sample on, every 16 cycles dout_o=32767 (+256 saturated).
REQ-028 All-zeros stream -> steady dout_o=-32768 every 16 cycles; same stream with POL=1 -> dout_o=32767.
REQ-029 Alternating 1,0,1,0 stream -> every presented sample dout_o=0.
REQ-030 All-ones stream with bit_valid_i toggled 1,0,1,0 -> samples every 32 cycles with values identical to REQ-027; integrators hold during the 0 cycles.
REQ-031 dout_ready_i=0 across two decimations -> dout_valid_o stays 1, overrun_o pulses once at the 2nd decimation, and dout_o shows the newer sample; ready asserted on a decimation edge -> no overrun pulse.
REQ-032 rst_ni pulled low for 1 cycle mid-frame with dout_valid_o=1 -> all outputs 0 immediately (asynchronous); next valid sample appears 49 cycles after release.
